// File: rtl/audio_pkg.sv
// Shared types and constants for the audio playback sequencer.
package audio_pkg;

   localparam int unsigned AUDIO_DATA_W = 32;
   localparam int unsigned SONG_ADDR_W  = 16;
   localparam int unsigned ROM_LAT_DEF  = 2;
   localparam int unsigned LAT_CNT_W    = 3;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StWait,
      StWrite
   } seq_state_e;

endpackage

// File: rtl/audio_sample_attenuator.sv
// Sample latch for the ROM read path; with AUDIO_SEQ_ATTEN_EN defined the sample is
// arithmetic-right-shifted by i_atten as it is latched.
module audio_sample_attenuator
   import audio_pkg::*;
#(
   parameter int unsigned DATA_W = AUDIO_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
`ifdef AUDIO_SEQ_ATTEN_EN
   input  logic [2:0]        i_atten,
`endif
   output logic [DATA_W-1:0] o_sample
);

   logic [DATA_W-1:0] w_shifted;
   logic [DATA_W-1:0] r_sample;

`ifdef AUDIO_SEQ_ATTEN_EN
   // Samples are two's complement, so the shift must preserve the sign.
   assign w_shifted = $unsigned($signed(i_data) >>> i_atten);
`else
   assign w_shifted = i_data;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sample <= '0;
      end else if (i_load) begin
         r_sample <= w_shifted;
      end
   end

   assign o_sample = r_sample;

endmodule

// File: rtl/audio_playback_sequencer.sv
// Walks a song ROM address range and feeds each sample exactly once into the audio FIFO.
// Optional AUDIO_SEQ_ATTEN_EN adds an i_atten port that attenuates samples as they are latched.
module audio_playback_sequencer
   import audio_pkg::*;
#(
   parameter int unsigned ADDR_W  = SONG_ADDR_W,
   parameter int unsigned DATA_W  = AUDIO_DATA_W,
   parameter int unsigned ROM_LAT = ROM_LAT_DEF
) (
   input  logic              i_clock_50,
   input  logic              i_resetn,
   input  logic              i_play,
   input  logic              i_stop,
   input  logic              i_pause,
   input  logic              i_loop_en,
   input  logic [ADDR_W-1:0] i_start_addr,
   input  logic [ADDR_W-1:0] i_end_addr,
`ifdef AUDIO_SEQ_ATTEN_EN
   input  logic [2:0]        i_atten,
`endif
   output logic [ADDR_W-1:0] o_rom_address,
   input  logic [DATA_W-1:0] i_rom_q,
   input  logic              i_audio_out_allowed,
   output logic [DATA_W-1:0] o_left_channel_audio_out,
   output logic [DATA_W-1:0] o_right_channel_audio_out,
   output logic              o_write_audio_out,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   seq_state_e           r_state, w_state_nxt;
   logic [ADDR_W-1:0]    r_start, w_start_nxt;
   logic [ADDR_W-1:0]    r_end, w_end_nxt;
   logic [ADDR_W-1:0]    r_addr, w_addr_nxt;
   logic [ADDR_W-1:0]    r_rom_address, w_rom_address_nxt;
   logic [LAT_CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [DATA_W-1:0]    r_chan;
   logic                 r_write, w_write_nxt;
   logic                 r_done, w_done_nxt;
   logic                 r_err, w_err_nxt;
   logic                 w_load;
   logic [DATA_W-1:0]    w_sample;

   audio_sample_attenuator #(
      .DATA_W (DATA_W)
   ) u_atten (
      .i_clk    (i_clock_50),
      .i_rst_n  (i_resetn),
      .i_load   (w_load),
      .i_data   (i_rom_q),
`ifdef AUDIO_SEQ_ATTEN_EN
      .i_atten  (i_atten),
`endif
      .o_sample (w_sample)
   );

   always_comb begin
      w_state_nxt       = r_state;
      w_start_nxt       = r_start;
      w_end_nxt         = r_end;
      w_addr_nxt        = r_addr;
      w_rom_address_nxt = r_rom_address;
      w_cnt_nxt         = '0;
      w_write_nxt       = 1'b0;
      w_done_nxt        = 1'b0;
      w_err_nxt         = 1'b0;
      w_load            = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (i_play && !i_stop) begin
               if (i_start_addr <= i_end_addr) begin
                  w_start_nxt       = i_start_addr;
                  w_end_nxt         = i_end_addr;
                  w_addr_nxt        = i_start_addr;
                  w_rom_address_nxt = i_start_addr;
                  w_state_nxt       = StFetch;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         StFetch: begin
            // Count covers ROM_LAT cycles from the address change, then rom_q is valid.
            if (r_cnt == LAT_CNT_W'(ROM_LAT)) begin
               w_load      = 1'b1;
               w_state_nxt = StWait;
            end else begin
               w_cnt_nxt = r_cnt + LAT_CNT_W'(1);
            end
         end
         StWait: begin
            if (i_audio_out_allowed && !i_pause) begin
               w_write_nxt = 1'b1;
               w_state_nxt = StWrite;
            end
         end
         StWrite: begin
            if (r_addr != r_end) begin
               w_addr_nxt        = r_addr + ADDR_W'(1);
               w_rom_address_nxt = r_addr + ADDR_W'(1);
               w_state_nxt       = StFetch;
            end else if (i_loop_en) begin
               w_addr_nxt        = r_start;
               w_rom_address_nxt = r_start;
               w_state_nxt       = StFetch;
            end else begin
               w_done_nxt  = 1'b1;
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase

      // A write already in flight completes; everything after it is cancelled.
      if (i_stop) begin
         w_state_nxt = StIdle;
         w_write_nxt = 1'b0;
         w_done_nxt  = 1'b0;
         w_cnt_nxt   = '0;
         w_load      = 1'b0;
      end
   end

   always_ff @(posedge i_clock_50 or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state       <= StIdle;
         r_start       <= '0;
         r_end         <= '0;
         r_addr        <= '0;
         r_rom_address <= '0;
         r_cnt         <= '0;
         r_chan        <= '0;
         r_write       <= 1'b0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_start       <= w_start_nxt;
         r_end         <= w_end_nxt;
         r_addr        <= w_addr_nxt;
         r_rom_address <= w_rom_address_nxt;
         r_cnt         <= w_cnt_nxt;
         r_write       <= w_write_nxt;
         r_done        <= w_done_nxt;
         r_err         <= w_err_nxt;
         if (w_write_nxt) begin
            r_chan <= w_sample;
         end
      end
   end

   assign o_rom_address             = r_rom_address;
   assign o_left_channel_audio_out  = r_chan;
   assign o_right_channel_audio_out = r_chan;
   assign o_write_audio_out         = r_write;
   assign o_busy                    = (r_state != StIdle);
   assign o_done                    = r_done;
   assign o_err                     = r_err;

endmodule

// File: tb/tb_audio_playback_sequencer.sv
// Scoreboard bench for audio_playback_sequencer with a fixed-latency ROM model (data = address).
module tb_audio_playback_sequencer;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ROM_LAT = 2;
   localparam int          PERIOD  = ROM_LAT + 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              play = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
   logic [ADDR_W-1:0] start_addr = '0, end_addr = '0;
   logic              allowed = 1'b0;
   logic [ADDR_W-1:0] rom_address;
   logic [DATA_W-1:0] rom_q;
   logic [DATA_W-1:0] left, right;
   logic              wr, busy, done, err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int wr_count = 0;
   int done_count = 0;
   int done_cyc = -1;
   int fall_cyc = -2;
   int wr_cycles[$];
   logic [DATA_W-1:0] exp_q[$];
   logic [ADDR_W-1:0] rom_pipe[ROM_LAT];

   audio_playback_sequencer #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .ROM_LAT (ROM_LAT)
   ) dut (
      .i_clock_50                (clk),
      .i_resetn                  (rst_n),
      .i_play                    (play),
      .i_stop                    (stop),
      .i_pause                   (pause),
      .i_loop_en                 (loop_en),
      .i_start_addr              (start_addr),
      .i_end_addr                (end_addr),
`ifdef AUDIO_SEQ_ATTEN_EN
      .i_atten                   (3'd0),
`endif
      .o_rom_address             (rom_address),
      .i_rom_q                   (rom_q),
      .i_audio_out_allowed       (allowed),
      .o_left_channel_audio_out  (left),
      .o_right_channel_audio_out (right),
      .o_write_audio_out         (wr),
      .o_busy                    (busy),
      .o_done                    (done),
      .o_err                     (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      rom_pipe[0] <= rom_address;
      for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
   end

   assign rom_q = {{(DATA_W-ADDR_W){1'b0}}, rom_pipe[ROM_LAT-1]};

   // Scoreboard monitor: every strobe pops one expected sample.
   initial begin
      logic prev_busy;
      logic [DATA_W-1:0] exp_v;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (wr) begin
               wr_count++;
               wr_cycles.push_back(cyc);
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL write_unexpected: got strobe with data %h, required no write", left);
               end else begin
                  exp_v = exp_q.pop_front();
                  if (left !== exp_v) begin
                     errors++;
                     $display("FAIL left_data: got %h, required %h", left, exp_v);
                  end
                  checks++;
                  if (right !== exp_v) begin
                     errors++;
                     $display("FAIL right_data: got %h, required %h", right, exp_v);
                  end
               end
            end
            if (done) begin
               done_count++;
               done_cyc = cyc;
            end
            if (prev_busy && !busy) fall_cyc = cyc;
            prev_busy = busy;
         end else begin
            prev_busy = 1'b0;
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, budget);
      end
      tick(2);
   endtask

   task automatic start_play(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
      start_addr = s;
      end_addr   = e;
      play       = 1'b1;
      tick();
      play       = 1'b0;
   endtask

   task automatic test_reset();
      tick(2);
      checks++;
      if (busy !== 1'b0 || wr !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got busy=%b wr=%b done=%b err=%b, required 0 0 0 0",
                  busy, wr, done, err);
      end
      checks++;
      if (rom_address !== '0 || left !== '0 || right !== '0) begin
         errors++;
         $display("FAIL reset_data: got addr=%h l=%h r=%h, required 0", rom_address, left, right);
      end
      rst_n = 1'b1;
      allowed = 1'b0;
      tick();
      start_play(16'd4, 16'd7);
      tick(8);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_prerun_busy: got %b, required 1", busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || wr !== 1'b0 || rom_address !== '0 || left !== '0) begin
         errors++;
         $display("FAIL reset_midwait: got busy=%b wr=%b addr=%h l=%h, required 0 0 0 0",
                  busy, wr, rom_address, left);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int base, dbase, pc;
      allowed = 1'b1;
      loop_en = 1'b0;
      base = wr_count;
      dbase = done_count;
      wr_cycles.delete();
      for (int a = 4; a <= 7; a++) exp_q.push_back(DATA_W'(a));
      pc = cyc;
      start_play(16'd4, 16'd7);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy: got %b, required 1", busy);
      end
      tick(3);
      start_addr = 16'd100;
      end_addr   = 16'd200;
      play = 1'b1;
      tick();
      play = 1'b0;
      wait_idle(100, "basic");
      checks++;
      if (wr_count - base != 4) begin
         errors++;
         $display("FAIL basic_count: got %0d writes, required 4", wr_count - base);
      end
      checks++;
      if (wr_cycles.size() < 4 || wr_cycles[0] != pc + PERIOD) begin
         errors++;
         $display("FAIL basic_first_latency: got %0d strobes, first at %0d, required cycle %0d",
                  wr_cycles.size(), (wr_cycles.size() > 0) ? wr_cycles[0] : -1, pc + PERIOD);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_cycles[i+1] - wr_cycles[i] != PERIOD) begin
               errors++;
               $display("FAIL basic_spacing: got %0d cycles, required %0d",
                        wr_cycles[i+1] - wr_cycles[i], PERIOD);
            end
         end
      end
      checks++;
      if (done_count - dbase != 1 || done_cyc != fall_cyc) begin
         errors++;
         $display("FAIL basic_done: got %0d pulses at cycle %0d (busy fell %0d), required 1 same",
                  done_count - dbase, done_cyc, fall_cyc);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_left_over: got %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      int base, rc;
      allowed = 1'b0;
      base = wr_count;
      wr_cycles.delete();
      for (int a = 20; a <= 22; a++) exp_q.push_back(DATA_W'(a));
      start_play(16'd20, 16'd22);
      tick(20);
      checks++;
      if (wr_count != base || left !== 32'd7) begin
         errors++;
         $display("FAIL bp_hold: got %0d writes, left=%h, required 0 writes, left=7",
                  wr_count - base, left);
      end
      allowed = 1'b1;
      rc = cyc;
      wait_idle(100, "bp");
      checks++;
      if (wr_cycles.size() == 0 || wr_cycles[0] != rc + 1) begin
         errors++;
         $display("FAIL bp_release: got first strobe at %0d, required %0d",
                  (wr_cycles.size() > 0) ? wr_cycles[0] : -1, rc + 1);
      end
      checks++;
      if (wr_count - base != 3 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_count: got %0d writes, %0d pending, required 3 and 0",
                  wr_count - base, exp_q.size());
      end
   endtask

   task automatic test_pause();
      int base, rc;
      allowed = 1'b1;
      base = wr_count;
      wr_cycles.delete();
      exp_q.push_back(32'd30);
      exp_q.push_back(32'd31);
      start_play(16'd30, 16'd31);
      pause = 1'b1;
      tick(15);
      checks++;
      if (wr_count != base || busy !== 1'b1) begin
         errors++;
         $display("FAIL pause_hold: got %0d writes busy=%b, required 0 writes busy=1",
                  wr_count - base, busy);
      end
      pause = 1'b0;
      rc = cyc;
      wait_idle(100, "pause");
      checks++;
      if (wr_cycles.size() != 2 || wr_cycles[0] != rc + 1) begin
         errors++;
         $display("FAIL pause_release: got %0d writes, first at %0d, required 2, first at %0d",
                  wr_cycles.size(), (wr_cycles.size() > 0) ? wr_cycles[0] : -1, rc + 1);
      end
   endtask

   task automatic test_loop();
      int base, dbase, n;
      allowed = 1'b1;
      loop_en = 1'b1;
      base = wr_count;
      dbase = done_count;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(32'd10);
         exp_q.push_back(32'd11);
      end
      start_play(16'd10, 16'd11);
      n = 0;
      while (wr_count < base + 6 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (wr_count - base != 6 || done_count != dbase) begin
         errors++;
         $display("FAIL loop_six: got %0d writes %0d done, required 6 writes 0 done",
                  wr_count - base, done_count - dbase);
      end
      loop_en = 1'b0;
      wait_idle(100, "loop");
      checks++;
      if (wr_count - base != 8 || done_count - dbase != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL loop_exit: got %0d writes %0d done %0d pending, required 8 1 0",
                  wr_count - base, done_count - dbase, exp_q.size());
      end
   endtask

   task automatic test_stop();
      int base, dbase, n;
      base = wr_count;
      stop = 1'b1;
      start_play(16'd1, 16'd2);
      stop = 1'b0;
      checks++;
      if (busy !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL stop_play_idle: got busy=%b err=%b, required 0 0", busy, err);
      end
      tick(10);
      checks++;
      if (wr_count != base) begin
         errors++;
         $display("FAIL stop_play_writes: got %0d writes, required 0", wr_count - base);
      end
      allowed = 1'b1;
      loop_en = 1'b0;
      base = wr_count;
      dbase = done_count;
      exp_q.push_back(32'd40);
      start_play(16'd40, 16'd45);
      n = 0;
      while (wr !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (wr !== 1'b1) begin
         errors++;
         $display("FAIL stop_wait_write: got no strobe in %0d cycles, required one", n);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if (busy !== 1'b0 || wr !== 1'b0) begin
         errors++;
         $display("FAIL stop_in_write: got busy=%b wr=%b, required 0 0", busy, wr);
      end
      tick(20);
      checks++;
      if (wr_count - base != 1 || done_count != dbase || exp_q.size() != 0) begin
         errors++;
         $display("FAIL stop_after: got %0d writes %0d done %0d pending, required 1 0 0",
                  wr_count - base, done_count - dbase, exp_q.size());
      end
   endtask

   task automatic test_error_edge();
      int base, dbase;
      start_play(16'd9, 16'd3);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL err_pulse: got err=%b busy=%b, required 1 0", err, busy);
      end
      tick();
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_width: got err=%b, required 0", err);
      end
      allowed = 1'b1;
      base = wr_count;
      dbase = done_count;
      exp_q.push_back(32'h0000_FFFF);
      start_play(16'hFFFF, 16'hFFFF);
      wait_idle(100, "top_addr");
      checks++;
      if (wr_count - base != 1 || done_count - dbase != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL top_addr_run: got %0d writes %0d done %0d pending, required 1 1 0",
                  wr_count - base, done_count - dbase, exp_q.size());
      end
      checks++;
      if (rom_address !== 16'hFFFF) begin
         errors++;
         $display("FAIL top_addr_nowrap: got %h, required ffff", rom_address);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running, required completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_pause();
      test_loop();
      test_stop();
      test_error_edge();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/audio_playback_sequencer.md
Name: audio_playback_sequencer

Overview:
Sequences sample playback from the song ROM into the Audio_Controller output FIFO. It walks a ROM address range, accounts for the ROM read latency and holds each sample until audio_out_allowed is high. It then issues a single-cycle write_audio_out, so every sample is written exactly once. It sits between the top-level control switches/keys, the ROM instance and Audio_Controller.

Parameters:
ADDR_W, 16, ROM address width
DATA_W, 32, sample width (matches Audio_Controller channels)
ROM_LAT, 2, cycles from rom_address change to valid rom_q (1..4)

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  async active-low reset
play  in  1  start-playback pulse (level tolerated, acted on only in IDLE)
stop  in  1  abort playback; highest priority
pause  in  1  level; holds the current sample, no FIFO writes
loop_en  in  1  restart at start_addr after end_addr; sampled at each end-of-clip
start_addr  in  ADDR_W  first sample address, latched on accepted play
end_addr  in  ADDR_W  last sample address (inclusive), latched on accepted play
rom_address  out  ADDR_W  ROM read address (registered)
rom_q  in  DATA_W  ROM read data
audio_out_allowed  in  1  FIFO has space
left_channel_audio_out  out  DATA_W  sample to FIFO
right_channel_audio_out  out  DATA_W  same sample as left
write_audio_out  out  1  one-cycle FIFO write strobe (registered)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a non-looping clip finishes
err  out  1  one-cycle pulse when play is rejected (start_addr > end_addr)

Behaviour:
- Reset (async, resetn=0): state=IDLE. rom_address=0, channel outputs=0, write_audio_out=0, busy=0, done=0, err=0. Internal addr, sample and latency counter are all 0.
- States: IDLE, FETCH, WAIT, WRITE.
- IDLE:
  - On play with start_addr<=end_addr: latch start/end, set addr=start, rom_address=start, go to FETCH.
  - On play with start_addr>end_addr: err=1 for one cycle, stay in IDLE.
- FETCH:
  - rom_address holds addr. The counter counts ROM_LAT cycles from FETCH entry.
  - In the cycle the count reaches ROM_LAT, rom_q is latched into sample. The next state is WAIT.
- WAIT:
  - Leave for WRITE only when audio_out_allowed=1 and pause=0.
  - Otherwise hold; the sample is held indefinitely.
- WRITE (exactly one cycle): write_audio_out=1, left=right=sample.
  - If addr!=end: addr+=1, rom_address=addr+1, go to FETCH.
  - If addr==end and loop_en=1: addr=start, go to FETCH.
  - If addr==end and loop_en=0: done=1 next cycle, go to IDLE.
- Throughput: with audio_out_allowed tied high, one write every ROM_LAT+3 cycles (5 at the default).
- Channel outputs change only on entry to WRITE and hold their value otherwise.
- stop overrides play and pause in any state:
  - Next state is IDLE with write_audio_out=0. If WRITE is current when stop arrives, that write still completes (strobe already registered).
  - done is not pulsed on a stop.
- play while busy is ignored. Latched start/end are unaffected by input changes during playback.
- start_addr==end_addr plays one sample (looping if loop_en=1).
- end_addr = 2^ADDR_W-1 terminates normally; addr never wraps past end.
- Pause asserted during FETCH: the fetch completes, then the block holds in WAIT.

Optional Feature:
AUDIO_SEQ_ATTEN_EN
- Defined: adds input port atten (3 bits). The sample is arithmetic-right-shifted (signed) by atten when latched in FETCH. The shift amount is applied per sample; latency is unchanged.
- Undefined: no atten port; sample=rom_q unmodified.

Decomposition:
- Shared package audio_pkg holds:
  - state enum (IDLE, FETCH, WAIT, WRITE)
  - AUDIO_DATA_W=32, SONG_ADDR_W=16
  - default ROM_LAT constant
- One sub-module is natural: audio_sample_attenuator (sample latch plus optional shift). It is instantiated in FETCH's latch path and is trivial when the macro is off.

Test Plan:
- Reset mid-WAIT (resetn low for 1 cycle): all outputs 0, busy=0, next play starts cleanly.
- Basic run: start=4, end=7, loop_en=0, allowed=1, ROM data=address. Exactly 4 write strobes with data 4,5,6,7, spaced 5 cycles apart. done pulses once, busy falls on the same cycle.
- Backpressure: allowed=0 for 20 cycles during WAIT. No strobe, data held; the strobe occurs exactly 1 cycle after allowed rises. No sample is duplicated or skipped.
- Loop: start=10, end=11, loop_en=1, run 6 writes. Sequence is 10,11,10,11,10,11. Clearing loop_en before the next end gives done after 11.
- Stop/priority: stop and play in the same IDLE cycle means no start. Stop asserted in WRITE: that strobe occurs, no further strobes, busy=0 next cycle, no done.
- Error/edge: start=9, end=3 gives an err pulse, busy stays 0. start=end=0xFFFF gives one write of sample 0xFFFF, then done.
